// File: rtl/mem_resp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_resp_pkg : shared bus width, IO map and FSM state type for mem_resp   |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
package mem_resp_pkg;

  localparam int BUS_W  = 32;
  localparam int LANES  = BUS_W / 8;
  localparam int IO_BIT = 22;
  localparam int WAIT_W = 2;

  localparam logic [IO_BIT-1:0] IO_LEDS_OFF   = 22'h00_0004;
  localparam logic [IO_BIT-1:0] IO_CYCLES_OFF = 22'h00_0008;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Unmapped IO offsets read as zero.
  function automatic logic [BUS_W-1:0] io_read(
    input logic [IO_BIT-1:0] off,
    input logic [7:0]        leds,
    input logic [BUS_W-1:0]  cycles
  );
    logic [BUS_W-1:0] val;
    val = '0;
    if (off == IO_LEDS_OFF) begin
      val = {{(BUS_W-8){1'b0}}, leds};
    end else if (off == IO_CYCLES_OFF) begin
      val = cycles;
    end
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_resp_if : CPU-side memory request/response bus                        |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
interface mem_resp_if;
  import mem_resp_pkg::*;

  logic [BUS_W-1:0] mem_addr;
  logic [BUS_W-1:0] mem_wdata;
  logic [LANES-1:0] mem_wmask;
  logic             mem_rstrb;
  logic             mem_wstrb;
  logic [BUS_W-1:0] mem_rdata;
  logic             mem_rbusy;
  logic             mem_wbusy;

  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb, mem_wstrb,
    input  mem_rdata, mem_rbusy, mem_wbusy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, mem_wstrb,
    output mem_rdata, mem_rbusy, mem_wbusy
  );

endinterface
`default_nettype wire

// File: rtl/mem_resp_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_ram : WORDS x 32 block RAM, synchronous read, byte-lane write         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_ram
  import mem_resp_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  wire logic             clk,
  input  wire logic             re,
  input  wire logic [LANES-1:0] we,
  input  wire logic [AW-1:0]    addr,
  input  wire logic [BUS_W-1:0] wdata,
  output logic      [BUS_W-1:0] rdata
);

  logic [BUS_W-1:0] mem_q [WORDS];
  logic [BUS_W-1:0] rdata_q;

  // Read-before-write: a same-edge read returns the old word.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[addr];
    end
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_resp : RAM + LEDS/CYCLES IO responder with optional wait states       |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  wire logic   clk,
  input  wire logic   rstn,
  mem_resp_if.slave   bus,
  output logic [7:0]  leds
);

  localparam int                AW      = $clog2(MEM_WORDS);
  localparam logic [WAIT_W-1:0] WS_LAST = WAIT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              rbusy_q, rbusy_d;
  logic              wbusy_q, wbusy_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_ram_q, rd_ram_d;
  logic [BUS_W-1:0]  io_rdata_q, io_rdata_d;
  logic [7:0]        leds_q, leds_d;
  logic [BUS_W-1:0]  cycles_q, cycles_d;

  logic              is_io;
  logic [IO_BIT-1:0] io_off;
  logic [AW-1:0]     ram_idx;
  logic              rd_acc;
  logic              wr_acc;
  logic              ram_re;
  logic [LANES-1:0]  ram_we;
  logic [BUS_W-1:0]  ram_rdata;
  logic              unused_addr_bits;

  assign is_io   = bus.mem_addr[IO_BIT];
  assign io_off  = {bus.mem_addr[IO_BIT-1:2], 2'b00};
  assign ram_idx = bus.mem_addr[AW+1:2];
  assign rd_acc  = bus.mem_rstrb && (state_q == ST_IDLE);
  assign wr_acc  = bus.mem_wstrb && (state_q == ST_IDLE);
  assign ram_re  = rd_acc && !is_io;
  assign ram_we  = {LANES{wr_acc && !is_io}} & bus.mem_wmask;

  assign unused_addr_bits = ^{bus.mem_addr[BUS_W-1:IO_BIT+1], bus.mem_addr[1:0]};

  mem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (bus.mem_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rbusy_d    = rbusy_q;
    wbusy_d    = wbusy_q;
    rd_valid_d = rd_valid_q;
    rd_ram_d   = rd_ram_q;
    io_rdata_d = io_rdata_q;
    leds_d     = leds_q;
    cycles_d   = cycles_q + 1'b1;

    if (wr_acc && is_io && (io_off == IO_LEDS_OFF) && bus.mem_wmask[0]) begin
      leds_d = bus.mem_wdata[7:0];
    end

    // IO reads are captured here; RAM reads come from the BRAM output register.
    if (rd_acc) begin
      rd_valid_d = 1'b1;
      rd_ram_d   = !is_io;
      io_rdata_d = is_io ? io_read(io_off, leds_q, cycles_q) : '0;
    end

    case (state_q)
      ST_IDLE: begin
        if ((rd_acc || wr_acc) && (WAIT_STATES > 0)) begin
          state_d = ST_BUSY;
          cnt_d   = WAIT_W'(1);
          rbusy_d = rd_acc;
          wbusy_d = wr_acc;
        end
      end
      ST_BUSY: begin
        if (cnt_q == WS_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rbusy_d = 1'b0;
          wbusy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rbusy_d = 1'b0;
        wbusy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rbusy_q    <= 1'b0;
      wbusy_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ram_q   <= 1'b0;
      io_rdata_q <= '0;
      leds_q     <= '0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rbusy_q    <= rbusy_d;
      wbusy_q    <= wbusy_d;
      rd_valid_q <= rd_valid_d;
      rd_ram_q   <= rd_ram_d;
      io_rdata_q <= io_rdata_d;
      leds_q     <= leds_d;
      cycles_q   <= cycles_d;
    end
  end

  assign bus.mem_rdata = !rd_valid_q ? '0 : (rd_ram_q ? ram_rdata : io_rdata_q);
  assign bus.mem_rbusy = rbusy_q;
  assign bus.mem_wbusy = wbusy_q;
  assign leds          = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_resp : scoreboard bench over WAIT_STATES = 0, 2 and 3 instances    |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_mem_resp;

  logic        clk = 1'b0;
  logic        rstn0 = 1'b0, rstn2 = 1'b0, rstn3 = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wmask = '0;
  logic        rstrb = 1'b0, wstrb = 1'b0;
  int          sel = 0;

  logic [31:0] rdata;
  logic        rbusy, wbusy;
  logic [7:0]  leds, leds0, leds2, leds3;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_resp_if bus0();
  mem_resp_if bus2();
  mem_resp_if bus3();

  assign bus0.mem_addr = addr;  assign bus2.mem_addr = addr;  assign bus3.mem_addr = addr;
  assign bus0.mem_wdata = wdata; assign bus2.mem_wdata = wdata; assign bus3.mem_wdata = wdata;
  assign bus0.mem_wmask = wmask; assign bus2.mem_wmask = wmask; assign bus3.mem_wmask = wmask;
  assign bus0.mem_rstrb = rstrb && (sel == 0);
  assign bus2.mem_rstrb = rstrb && (sel == 2);
  assign bus3.mem_rstrb = rstrb && (sel == 3);
  assign bus0.mem_wstrb = wstrb && (sel == 0);
  assign bus2.mem_wstrb = wstrb && (sel == 2);
  assign bus3.mem_wstrb = wstrb && (sel == 3);

  mem_resp #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rstn(rstn0), .bus(bus0), .leds(leds0));
  mem_resp #(.MEM_WORDS(1024), .WAIT_STATES(2)) u_dut2 (.clk(clk), .rstn(rstn2), .bus(bus2), .leds(leds2));
  mem_resp #(.MEM_WORDS(1024), .WAIT_STATES(3)) u_dut3 (.clk(clk), .rstn(rstn3), .bus(bus3), .leds(leds3));

  always_comb begin
    rdata = bus0.mem_rdata; rbusy = bus0.mem_rbusy; wbusy = bus0.mem_wbusy; leds = leds0;
    if (sel == 2) begin
      rdata = bus2.mem_rdata; rbusy = bus2.mem_rbusy; wbusy = bus2.mem_wbusy; leds = leds2;
    end else if (sel == 3) begin
      rdata = bus3.mem_rdata; rbusy = bus3.mem_rbusy; wbusy = bus3.mem_wbusy; leds = leds3;
    end
  end

  // Called 1 time unit after a rising edge; the strobe is taken at the next edge.
  task automatic pulse(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; wmask = m; rstrb = r; wstrb = w;
    @(posedge clk); #1;
    rstrb = 1'b0; wstrb = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while ((rbusy === 1'b1 || wbusy === 1'b1) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s <= 2; s += 2) begin
      sel = s; #0;
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata sel=%0d got=%h exp=0", s, rdata); end
      checks++; if (rbusy !== 1'b0)  begin failures++; $display("FAIL reset_rbusy sel=%0d got=%b exp=0", s, rbusy); end
      checks++; if (wbusy !== 1'b0)  begin failures++; $display("FAIL reset_wbusy sel=%0d got=%b exp=0", s, wbusy); end
      checks++; if (leds !== 8'h0)   begin failures++; $display("FAIL reset_leds sel=%0d got=%h exp=0", s, leds); end
    end
  endtask

  task automatic test_ws0_rw;
    logic [31:0] e;
    sel = 0;
    pulse(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (wbusy !== 1'b0) begin failures++; $display("FAIL ws0_wbusy got=%b exp=0", wbusy); end
    exp_q.push_back(32'hDEADBEEF);
    pulse(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    e = exp_q.pop_front();
    checks++; if (rbusy !== 1'b0) begin failures++; $display("FAIL ws0_rbusy got=%b exp=0", rbusy); end
    checks++; if (rdata !== e) begin failures++; $display("FAIL ws0_read got=%h exp=%h", rdata, e); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (rdata !== e) begin failures++; $display("FAIL ws0_hold got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_mask;
    logic [31:0] e;
    sel = 0;
    pulse(1'b0, 1'b1, 32'h10, 32'h00000055, 4'h1);
    exp_q.push_back(32'hDEADBE55);
    pulse(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    e = exp_q.pop_front();
    checks++; if (rdata !== e) begin failures++; $display("FAIL mask_lane0 got=%h exp=%h", rdata, e); end
    pulse(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    exp_q.push_back(32'hDEADBE55);
    pulse(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    e = exp_q.pop_front();
    checks++; if (rdata !== e) begin failures++; $display("FAIL mask_zero got=%h exp=%h", rdata, e); end
    pulse(1'b0, 1'b1, 32'h10, 32'h11223344, 4'h6);
    exp_q.push_back(32'hDE223355);
    pulse(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    e = exp_q.pop_front();
    checks++; if (rdata !== e) begin failures++; $display("FAIL mask_mid got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_alias;
    logic [31:0] e;
    sel = 0;
    pulse(1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF);
    exp_q.push_back(32'h12345678);
    pulse(1'b1, 1'b0, 32'h0000, 32'h0, 4'h0);
    e = exp_q.pop_front();
    checks++; if (rdata !== e) begin failures++; $display("FAIL alias_low got=%h exp=%h", rdata, e); end
    exp_q.push_back(32'h12345678);
    pulse(1'b1, 1'b0, 32'h8000_1000, 32'h0, 4'h0);
    e = exp_q.pop_front();
    checks++; if (rdata !== e) begin failures++; $display("FAIL alias_high got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_io;
    logic [31:0] e, c1;
    sel = 0;
    pulse(1'b0, 1'b1, 32'h400004, 32'h000000A5, 4'h1);
    checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL leds_write got=%h exp=a5", leds); end
    pulse(1'b0, 1'b1, 32'h400004, 32'h0000005A, 4'h2);
    checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL leds_nolane0 got=%h exp=a5", leds); end
    exp_q.push_back(32'h000000A5);
    pulse(1'b1, 1'b0, 32'h400004, 32'h0, 4'h0);
    e = exp_q.pop_front();
    checks++; if (rdata !== e) begin failures++; $display("FAIL leds_read got=%h exp=%h", rdata, e); end
    exp_q.push_back(32'h0);
    pulse(1'b1, 1'b0, 32'h40000C, 32'h0, 4'h0);
    e = exp_q.pop_front();
    checks++; if (rdata !== e) begin failures++; $display("FAIL io_unmapped got=%h exp=%h", rdata, e); end
    pulse(1'b1, 1'b0, 32'h400008, 32'h0, 4'h0);
    c1 = rdata;
    repeat (9) begin @(posedge clk); #1; end
    exp_q.push_back(c1 + 32'd10);
    pulse(1'b1, 1'b0, 32'h400008, 32'h0, 4'h0);
    e = exp_q.pop_front();
    checks++; if (rdata !== e) begin failures++; $display("FAIL cycles_delta got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_simul;
    logic [31:0] e;
    int n;
    sel = 2;
    pulse(1'b0, 1'b1, 32'h20, 32'h11111111, 4'hF);
    checks++; if (wbusy !== 1'b1) begin failures++; $display("FAIL ws2_wbusy got=%b exp=1", wbusy); end
    wait_idle(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL ws2_wlen got=%0d exp=2", n); end
    exp_q.push_back(32'h11111111);
    pulse(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    checks++; if ({rbusy, wbusy} !== 2'b11) begin failures++; $display("FAIL simul_busy got=%b exp=11", {rbusy, wbusy}); end
    wait_idle(n);
    e = exp_q.pop_front();
    checks++; if (n !== 2) begin failures++; $display("FAIL simul_len got=%0d exp=2", n); end
    checks++; if (rdata !== e) begin failures++; $display("FAIL simul_prewrite got=%h exp=%h", rdata, e); end
    exp_q.push_back(32'hCAFEF00D);
    pulse(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    wait_idle(n);
    e = exp_q.pop_front();
    checks++; if (rdata !== e) begin failures++; $display("FAIL simul_post got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_wait_states;
    logic [31:0] e;
    int n;
    sel = 2;
    pulse(1'b0, 1'b1, 32'h30, 32'h0BADCAFE, 4'hF); wait_idle(n);
    pulse(1'b0, 1'b1, 32'h34, 32'h77777777, 4'hF); wait_idle(n);
    exp_q.push_back(32'h0BADCAFE);
    pulse(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    checks++; if (rbusy !== 1'b1) begin failures++; $display("FAIL ws2_busy1 got=%b exp=1", rbusy); end
    pulse(1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
    checks++; if (rbusy !== 1'b1) begin failures++; $display("FAIL ws2_busy2 got=%b exp=1", rbusy); end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++; if (rbusy !== 1'b0) begin failures++; $display("FAIL ws2_done got=%b exp=0", rbusy); end
    checks++; if (rdata !== e) begin failures++; $display("FAIL ws2_data got=%h exp=%h", rdata, e); end
    @(posedge clk); #1;
    checks++; if ({rbusy, rdata} !== {1'b0, e}) begin failures++; $display("FAIL ws2_ignored got=%b/%h exp=0/%h", rbusy, rdata, e); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] e;
    int n;
    sel = 3;
    pulse(1'b0, 1'b1, 32'h40, 32'h13579BDF, 4'hF); wait_idle(n);
    pulse(1'b0, 1'b1, 32'h400004, 32'h0000003C, 4'h1); wait_idle(n);
    checks++; if (leds !== 8'h3C) begin failures++; $display("FAIL ws3_leds got=%h exp=3c", leds); end
    pulse(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    #2 rstn3 = 1'b0;
    #1;
    checks++; if (rbusy !== 1'b0) begin failures++; $display("FAIL rst_mid_rbusy got=%b exp=0", rbusy); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_rdata got=%h exp=0", rdata); end
    checks++; if (leds !== 8'h0) begin failures++; $display("FAIL rst_mid_leds got=%h exp=0", leds); end
    #2 rstn3 = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(32'h13579BDF);
    pulse(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    wait_idle(n);
    e = exp_q.pop_front();
    checks++; if (n !== 3) begin failures++; $display("FAIL ws3_rlen got=%0d exp=3", n); end
    checks++; if (rdata !== e) begin failures++; $display("FAIL ws3_persist got=%h exp=%h", rdata, e); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rstn0 = 1'b1; rstn2 = 1'b1; rstn3 = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_ws0_rw();
    test_mask();
    test_alias();
    test_io();
    test_simul();
    test_wait_states();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning extra busy cycles per access (range 0..3).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-004 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port mem_addr  input  32  byte address from the CPU; bits [1:0] ignored.
REQ-006 SHALL have port mem_wdata  input  32  write data.
REQ-007 SHALL have port mem_wmask  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-008 SHALL have port mem_rstrb  input  1  one-cycle read request pulse.
REQ-009 SHALL have port mem_wstrb  input  1  one-cycle write request pulse.
REQ-010 SHALL have port mem_rdata  output  32  registered read data.
REQ-011 SHALL have port mem_rbusy  output  1  high while a read is in progress.
REQ-012 SHALL have port mem_wbusy  output  1  high while a write is in progress.
REQ-013 SHALL have port leds  output  8  LED register contents.

Function
REQ-014 SHALL decode mem_addr[22]=0 as RAM, word index = mem_addr[log2(MEM_WORDS)+1:2], with higher address bits ignored (aliasing wrap-around).
REQ-015 SHALL decode mem_addr[22]=1 as IO: offset 0x04 = LEDS (R/W, low 8 bits), offset 0x08 = CYCLES (read-only, 32-bit free-running counter); other IO offsets read 0 and ignore writes.
REQ-016 SHALL implement FSM states IDLE, BUSY; IDLE->BUSY on an accepted strobe when WAIT_STATES>0; BUSY->IDLE when the wait counter reaches WAIT_STATES; IDLE->IDLE otherwise.
REQ-017 SHALL accept strobes only in IDLE; a strobe in BUSY SHALL have no effect.
REQ-018 SHALL, for a read accepted at edge N, assert mem_rbusy during cycles N+1..N+WAIT_STATES, and present valid mem_rdata with mem_rbusy low from cycle N+1+WAIT_STATES.
REQ-019 SHALL hold mem_rdata stable until the next accepted read.
REQ-020 SHALL commit a write at the accepting edge, updating only lanes with mem_wmask bit set; mem_wmask=0 writes nothing.
REQ-021 SHALL assert mem_wbusy during cycles N+1..N+WAIT_STATES after a write accepted at edge N.
REQ-022 SHALL, when mem_rstrb and mem_wstrb are accepted together, perform both; mem_rdata returns pre-write contents; both busy flags follow one shared counter.
REQ-023 SHALL increment CYCLES every cycle out of reset, wrapping 0xFFFFFFFF->0; a CYCLES read returns the value at the accepting edge.
REQ-024 SHALL update leds on the edge after an LEDS write with wmask[0]=1.

Reset
REQ-025 SHALL, on rstn low, asynchronously force FSM=IDLE, wait counter=0, mem_rdata=0, mem_rbusy=0, mem_wbusy=0, leds=0, CYCLES=0.
REQ-026 SHALL NOT reset RAM contents; RAM SHALL be zero-initialised at configuration.
REQ-027 SHALL, on reset mid-access, abandon any pending read; a write already committed at its accepting edge SHALL persist.

Structure
REQ-028 SHALL place IO base bit, LEDS/CYCLES offsets and the BUS width macro in the shared define header.
REQ-029 SHALL instantiate one sub-module mem_ram: synchronous-read, byte-lane-write BRAM of MEM_WORDS x 32.

Verification
REQ-030 SHALL cover: WAIT_STATES=0, write 0xDEADBEEF mask 0xF to 0x10, read 0x10 -> rdata=0xDEADBEEF one cycle after rstrb, rbusy never high.
REQ-031 SHALL cover: over 0xDEADBEEF, write 0x00000055 mask 0x1 to 0x10, read -> 0xDEADBE55.
REQ-032 SHALL cover: WAIT_STATES=2, read strobe at N -> rbusy high N+1..N+2, data valid N+3; second rstrb at N+1 ignored.
REQ-033 SHALL cover: MEM_WORDS=1024, write 0x12345678 to 0x1000, read 0x0000 -> 0x12345678 (alias).
REQ-034 SHALL cover: write 0xA5 to 0x400004 -> leds=0xA5 next cycle; two CYCLES reads 10 cycles apart differ by 10.
REQ-035 SHALL cover: rstn low during a WAIT_STATES=3 read -> rbusy=0, rdata=0, leds=0 immediately; RAM data written before reset still reads back.
